// File: rtl/axi_mst_rd_arb_if.sv
// Request/result port between the read arbiter and the AXI master read controller.
// Bus widths come from the AXI_* width macros; the fallbacks below apply when none are supplied.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_LOCK_WIDTH
`define AXI_LOCK_WIDTH 1
`endif
`ifndef AXI_CACHE_WIDTH
`define AXI_CACHE_WIDTH 4
`endif
`ifndef AXI_PROT_WIDTH
`define AXI_PROT_WIDTH 3
`endif
`ifndef AXI_QOS_WIDTH
`define AXI_QOS_WIDTH 4
`endif
`ifndef AXI_REGION_WIDTH
`define AXI_REGION_WIDTH 4
`endif

interface axi_mst_rd_arb_if;
  logic                          rd_req_en;
  logic [`AXI_ID_WIDTH-1:0]      rd_id;
  logic [`AXI_ADDR_WIDTH-1:0]    rd_base_addr;
  logic [`AXI_LEN_WIDTH-1:0]     rd_len;
  logic [`AXI_SIZE_WIDTH-1:0]    rd_size;
  logic [`AXI_BURST_WIDTH-1:0]   rd_burst;
  logic [`AXI_LOCK_WIDTH-1:0]    rd_lock;
  logic [`AXI_CACHE_WIDTH-1:0]   rd_cache;
  logic [`AXI_PROT_WIDTH-1:0]    rd_prot;
  logic [`AXI_QOS_WIDTH-1:0]     rd_qos;
  logic [`AXI_REGION_WIDTH-1:0]  rd_region;
  logic                          rd_result_en;
  logic [`AXI_DATA_WIDTH-1:0]    rd_result_data;

  modport master (
    output rd_req_en, rd_id, rd_base_addr, rd_len, rd_size, rd_burst,
           rd_lock, rd_cache, rd_prot, rd_qos, rd_region,
    input  rd_result_en, rd_result_data
  );

  modport slave (
    input  rd_req_en, rd_id, rd_base_addr, rd_len, rd_size, rd_burst,
           rd_lock, rd_cache, rd_prot, rd_qos, rd_region,
    output rd_result_en, rd_result_data
  );
endinterface

// File: rtl/axi_mst_rd_arb.sv
// Round-robin arbiter sharing one single-outstanding AXI read controller among NUM_REQ clients.
// Optional AXI_RD_ARB_HIPRI_EN: requester 0 always wins and does not advance the round-robin pointer.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_LOCK_WIDTH
`define AXI_LOCK_WIDTH 1
`endif
`ifndef AXI_CACHE_WIDTH
`define AXI_CACHE_WIDTH 4
`endif
`ifndef AXI_PROT_WIDTH
`define AXI_PROT_WIDTH 3
`endif
`ifndef AXI_QOS_WIDTH
`define AXI_QOS_WIDTH 4
`endif
`ifndef AXI_REGION_WIDTH
`define AXI_REGION_WIDTH 4
`endif

module axi_mst_rd_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ),
  parameter logic [2:0]  RD_SIZE = 3'd2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*`AXI_ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*`AXI_LEN_WIDTH-1:0]   req_len,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [`AXI_DATA_WIDTH-1:0]          rsp_data,
  output logic                                busy,
  axi_mst_rd_arb_if.master                    rd
);

  localparam int unsigned AW = `AXI_ADDR_WIDTH;
  localparam int unsigned LW = `AXI_LEN_WIDTH;
  localparam int unsigned DW = `AXI_DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    grant_q;
  logic [AW-1:0]       addr_q;
  logic [LW-1:0]       len_q;
  logic                req_en_q;

  logic [AW-1:0]       addr_a [NUM_REQ];
  logic [LW-1:0]       len_a  [NUM_REQ];
  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;
  logic [IDX_W-1:0]    cand_idx;
  int unsigned         cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g] = req_addr[g*AW +: AW];
    assign len_a[g]  = req_len[g*LW +: LW];
  end

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!sel_found && req_valid[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
`ifdef AXI_RD_ARB_HIPRI_EN
    if (req_valid[0]) begin
      sel_found = 1'b1;
      sel_idx   = '0;
    end
`endif
  end

  // Arbitration / sequencing FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_q   <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      req_en_q  <= 1'b0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      req_en_q  <= 1'b0;
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant_q   <= sel_idx;
            addr_q    <= addr_a[sel_idx];
            len_q     <= len_a[sel_idx];
            req_en_q  <= 1'b1;
            req_ready <= NUM_REQ'(1) << sel_idx;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef AXI_RD_ARB_HIPRI_EN
          if (grant_q != '0)
`endif
            rr_ptr <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
          state <= WAIT;
        end
        WAIT: begin
          if (rd.rd_result_en) begin
            rsp_data  <= rd.rd_result_data;
            rsp_valid <= NUM_REQ'(1) << grant_q;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd.rd_req_en    = req_en_q;
  assign rd.rd_id        = `AXI_ID_WIDTH'(grant_q);
  assign rd.rd_base_addr = addr_q;
  assign rd.rd_len       = len_q;
  assign rd.rd_size      = `AXI_SIZE_WIDTH'(RD_SIZE);
  assign rd.rd_burst     = `AXI_BURST_WIDTH'(2'b01);
  assign rd.rd_lock      = '0;
  assign rd.rd_cache     = '0;
  assign rd.rd_prot      = '0;
  assign rd.rd_qos       = '0;
  assign rd.rd_region    = '0;

  logic unused_ok;
  assign unused_ok = ^DW;

endmodule

// File: tb/tb_axi_mst_rd_arb.sv
// Directed self-checking bench for axi_mst_rd_arb (NUM_REQ=4).
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif

module tb_axi_mst_rd_arb;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = `AXI_ADDR_WIDTH;
  localparam int unsigned LW = `AXI_LEN_WIDTH;
  localparam int unsigned DW = `AXI_DATA_WIDTH;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       req_valid;
  logic [N*AW-1:0]    req_addr;
  logic [N*LW-1:0]    req_len;
  logic [N-1:0]       req_ready;
  logic [N-1:0]       rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               busy;

  logic [AW-1:0] a_tab [N];
  logic [LW-1:0] l_tab [N];

  int n_cmp = 0;
  int n_bad = 0;

  axi_mst_rd_arb_if rd_if ();

  axi_mst_rd_arb #(.NUM_REQ(4), .IDX_W(2), .RD_SIZE(3'd2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .rd        (rd_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_addr[g*AW +: AW] = a_tab[g];
    assign req_len[g*LW +: LW]  = l_tab[g];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction starting in IDLE with req_valid[idx] the expected winner.
  task automatic txn(input int idx, input bit drop, input logic [DW-1:0] data);
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    tick();
    chk("issue_req_en", 64'(rd_if.rd_req_en), 64'd1);
    chk("issue_id", 64'(rd_if.rd_id), 64'(idx));
    chk("issue_ready", 64'(req_ready), 64'(oh));
    chk("issue_addr", 64'(rd_if.rd_base_addr), 64'(a_tab[idx]));
    chk("issue_len", 64'(rd_if.rd_len), 64'(l_tab[idx]));
    chk("issue_busy", 64'(busy), 64'd1);
    if (drop) req_valid[idx] = 1'b0;
    tick();
    chk("wait_req_en", 64'(rd_if.rd_req_en), 64'd0);
    chk("wait_ready", 64'(req_ready), 64'd0);
    chk("wait_busy", 64'(busy), 64'd1);
    rd_if.rd_result_en   = 1'b1;
    rd_if.rd_result_data = data;
    tick();
    rd_if.rd_result_en = 1'b0;
    chk("rsp_valid", 64'(rsp_valid), 64'(oh));
    chk("rsp_data", 64'(rsp_data), 64'(data));
    chk("rsp_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    a_tab[0] = 32'h0000_0100; l_tab[0] = 8'd0;
    a_tab[1] = 32'h0000_0200; l_tab[1] = 8'd1;
    a_tab[2] = 32'h0000_1000; l_tab[2] = 8'd3;
    a_tab[3] = 32'h0000_300C; l_tab[3] = 8'd7;
    rd_if.rd_result_en   = 1'b0;
    rd_if.rd_result_data = '0;

    // reset state
    repeat (3) tick();
    chk("rst_req_en", 64'(rd_if.rd_req_en), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_id", 64'(rd_if.rd_id), 64'd0);
    chk("rst_addr", 64'(rd_if.rd_base_addr), 64'd0);
    chk("const_size", 64'(rd_if.rd_size), 64'd2);
    chk("const_burst", 64'(rd_if.rd_burst), 64'd1);
    chk("const_misc", 64'({rd_if.rd_lock, rd_if.rd_cache, rd_if.rd_prot,
                            rd_if.rd_qos, rd_if.rd_region}), 64'd0);
    rst_n = 1'b1;

    // spurious result in IDLE
    rd_if.rd_result_en = 1'b1;
    rd_if.rd_result_data = 32'h1234_5678;
    tick();
    rd_if.rd_result_en = 1'b0;
    chk("idle_spur_rsp", 64'(rsp_valid), 64'd0);
    chk("idle_spur_busy", 64'(busy), 64'd0);
    chk("idle_spur_req_en", 64'(rd_if.rd_req_en), 64'd0);

    // single request from requester 2
    req_valid = 4'b0100;
    txn(2, 1'b1, 32'hDEAD_BEEF);
    tick();
    chk("single_rsp_clear", 64'(rsp_valid), 64'd0);

`ifndef AXI_RD_ARB_HIPRI_EN
    // wrap: rr_ptr=3 after granting 2
    req_valid = 4'b1001;
    txn(3, 1'b1, 32'hA5A5_0003);
    txn(0, 1'b1, 32'hA5A5_0000);
    // rr_ptr now 1, so 1 beats 0
    req_valid = 4'b0011;
    txn(1, 1'b1, 32'hA5A5_0001);
    txn(0, 1'b1, 32'hA5A5_1000);

    // spurious result during ISSUE (rr_ptr=1)
    req_valid = 4'b0010;
    tick();
    chk("iss_spur_req_en", 64'(rd_if.rd_req_en), 64'd1);
    chk("iss_spur_id", 64'(rd_if.rd_id), 64'd1);
    req_valid = '0;
    rd_if.rd_result_en = 1'b1;
    rd_if.rd_result_data = 32'h0BAD_0BAD;
    tick();
    rd_if.rd_result_en = 1'b0;
    chk("iss_spur_rsp", 64'(rsp_valid), 64'd0);
    chk("iss_spur_busy", 64'(busy), 64'd1);
    tick();
    chk("iss_spur_still_wait", 64'(busy), 64'd1);
    rd_if.rd_result_en = 1'b1;
    rd_if.rd_result_data = 32'h600D_600D;
    tick();
    rd_if.rd_result_en = 1'b0;
    chk("iss_spur_final_rsp", 64'(rsp_valid), 64'b0010);
    chk("iss_spur_final_data", 64'(rsp_data), 64'h600D_600D);

    // all four held from reset: 0,1,2,3,0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    txn(0, 1'b0, 32'h0000_0A00);
    txn(1, 1'b0, 32'h0000_0A01);
    txn(2, 1'b0, 32'h0000_0A02);
    txn(3, 1'b0, 32'h0000_0A03);
    txn(0, 1'b0, 32'h0000_0A04);
    req_valid = '0;
    tick();
`else
    // requester 0 dominates while held, then round-robin among the rest
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    txn(0, 1'b0, 32'h0000_0B00);
    txn(0, 1'b0, 32'h0000_0B01);
    txn(0, 1'b0, 32'h0000_0B02);
    req_valid[0] = 1'b0;
    txn(1, 1'b0, 32'h0000_0B11);
    txn(2, 1'b0, 32'h0000_0B12);
    txn(3, 1'b0, 32'h0000_0B13);
    req_valid = '0;
    tick();
`endif

    // reset in the middle of WAIT
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    chk("midwait_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midwait_rst_busy", 64'(busy), 64'd0);
    chk("midwait_rst_id", 64'(rd_if.rd_id), 64'd0);
    chk("midwait_rst_addr", 64'(rd_if.rd_base_addr), 64'd0);
    rd_if.rd_result_en = 1'b1;
    rd_if.rd_result_data = 32'hFFFF_0000;
    tick();
    chk("midwait_rst_rsp", 64'(rsp_valid), 64'd0);
    rd_if.rd_result_en = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_rsp", 64'(rsp_valid), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    req_valid = 4'b0010;
    txn(1, 1'b1, 32'hCAFE_F00D);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
